// File: rtl/b200_reset_sequencer.sv
// Clock-ready / reset sequencer: filters PLL lock, then releases GPIF, bus and radio resets in order.
// Optional build macro RESET_SEQ_LOSS_CNT_EN enables the saturating RUN lock-loss counter.
module b200_reset_sequencer #(
    parameter int HOLD_CYCLES = 65535,
    parameter int LOCK_FILTER = 16,
    parameter int STAGE_GAP   = 16
) (
    input  logic       bus_clk,
    input  logic       reset_global,
    input  logic       locked,
    input  logic       sw_reset_req,
    input  logic       clear_sticky,
    output logic       gpif_rst_req,
    output logic       bus_rst_req,
    output logic       radio_rst_req,
    output logic       clocks_ready,
    output logic [2:0] seq_state,
    output logic       lock_lost_sticky,
    output logic [7:0] lock_loss_count
);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        HOLD      = 3'd1,
        REL_GPIF  = 3'd2,
        REL_BUS   = 3'd3,
        REL_RADIO = 3'd4,
        RUN       = 3'd5
    } state_t;

    localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FLT_W   = $clog2(LOCK_FILTER + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [FLT_W-1:0] FLT_FULL  = FLT_W'(LOCK_FILTER);

    logic [1:0]       sync_q;
    logic [FLT_W-1:0] filt_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic             lock_s, lock_ok, loss_run;

    assign lock_s  = sync_q[1];
    // Qualified by lock_s so a low sample drops lock_ok before the counter clears.
    assign lock_ok = lock_s && (filt_q == FLT_FULL);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_ok) state_d = HOLD;
            end
            HOLD: begin
                if (!lock_ok)                 state_d = WAIT_LOCK;
                else if (sw_reset_req)        cnt_d   = '0;
                else if (cnt_q == HOLD_LAST)  state_d = REL_GPIF;
            end
            REL_GPIF: begin
                if (!lock_ok)                 state_d = WAIT_LOCK;
                else if (sw_reset_req)        state_d = HOLD;
                else if (cnt_q == GAP_LAST)   state_d = REL_BUS;
            end
            REL_BUS: begin
                if (!lock_ok)                 state_d = WAIT_LOCK;
                else if (sw_reset_req)        state_d = HOLD;
                else if (cnt_q == GAP_LAST)   state_d = REL_RADIO;
            end
            REL_RADIO: begin
                if (!lock_ok)                 state_d = WAIT_LOCK;
                else if (sw_reset_req)        state_d = HOLD;
                else if (cnt_q == GAP_LAST)   state_d = RUN;
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_ok)                 state_d = WAIT_LOCK;
                else if (sw_reset_req)        state_d = HOLD;
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
        // Every state change starts the next interval from zero.
        if (state_d != state_q) cnt_d = '0;
    end

    assign loss_run  = (state_q == RUN) && (state_d == WAIT_LOCK);
    assign seq_state = state_q;

    always_ff @(posedge bus_clk or posedge reset_global) begin
        if (reset_global) begin
            sync_q           <= '0;
            filt_q           <= '0;
            cnt_q            <= '0;
            state_q          <= WAIT_LOCK;
            gpif_rst_req     <= 1'b1;
            bus_rst_req      <= 1'b1;
            radio_rst_req    <= 1'b1;
            clocks_ready     <= 1'b0;
            lock_lost_sticky <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], locked};
            if (!lock_s)
                filt_q <= '0;
            else if (filt_q != FLT_FULL)
                filt_q <= filt_q + FLT_W'(1);
            cnt_q   <= cnt_q_next();
            state_q <= state_d;
            // Outputs decode state_d so they move on the same edge as seq_state.
            gpif_rst_req  <= !(state_d == REL_GPIF || state_d == REL_BUS ||
                               state_d == REL_RADIO || state_d == RUN);
            bus_rst_req   <= !(state_d == REL_BUS || state_d == REL_RADIO || state_d == RUN);
            radio_rst_req <= !(state_d == REL_RADIO || state_d == RUN);
            clocks_ready  <= (state_d == RUN);
            if (loss_run)
                lock_lost_sticky <= 1'b1;
            else if (clear_sticky)
                lock_lost_sticky <= 1'b0;
        end
    end

    function automatic logic [CNT_W-1:0] cnt_q_next();
        return cnt_d;
    endfunction

`ifdef RESET_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt_q;

    always_ff @(posedge bus_clk or posedge reset_global) begin
        if (reset_global)
            loss_cnt_q <= 8'h00;
        else if (loss_run && loss_cnt_q != 8'hFF)
            loss_cnt_q <= loss_cnt_q + 8'h01;
    end

    assign lock_loss_count = loss_cnt_q;
`else
    assign lock_loss_count = 8'h00;
`endif

endmodule
